// File: rtl/emif_reg_bank.sv
// Register bank slave for the DSP asynchronous external-memory bus: R/W control registers,
// read-only status words and a sticky, maskable fault latch driving the active-low interrupt.
module emif_reg_bank #(
  parameter int                ADDR_W      = 14,
  parameter int                DATA_W      = 16,
  parameter logic [ADDR_W-1:0] BASE        = 14'h0040,
  parameter int                N_OUT       = 4,
  parameter int                N_IN        = 4,
  parameter int                FAULT_W     = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] ID          = 16'h4001
) (
  input  logic                    CLK,
  input  logic                    RESETn,
  input  logic [ADDR_W-1:0]       Addr,
  input  logic [DATA_W-1:0]       DATA_IN,
  input  logic                    CSn,
  input  logic                    WEn,
  input  logic                    OEn,
  output logic [DATA_W-1:0]       DATA_OUT,
  output logic                    DATA_OE,
  output logic [N_OUT*DATA_W-1:0] OUT_REGS,
  output logic [N_OUT-1:0]        OUT_WSTB,
  input  logic [N_IN*DATA_W-1:0]  IN_REGS,
  input  logic [FAULT_W-1:0]      FAULT_INPUT,
  output logic                    FAULT_XINT
);

  localparam int S = SYNC_STAGES;
  localparam logic [3:0]        OFF_ID   = 4'h0;
  localparam logic [3:0]        OFF_RAW  = 4'h1;
  localparam logic [3:0]        OFF_LAT  = 4'h2;
  localparam logic [3:0]        OFF_MASK = 4'h3;
  localparam logic [ADDR_W-5:0] HI_CTL   = (ADDR_W-4)'(0);
  localparam logic [ADDR_W-5:0] HI_OUT   = (ADDR_W-4)'(1);
  localparam logic [ADDR_W-5:0] HI_IN    = (ADDR_W-4)'(2);

  logic                      rst_meta_q, rst_n_q;
  logic [S-1:0]              cs_sync_q, cs_sync_d, we_sync_q, we_sync_d;
  logic [S-1:0]              oe_sync_q, oe_sync_d, fill_q, fill_d;
  logic [S-1:0][ADDR_W-1:0]  addr_sync_q, addr_sync_d;
  logic [S-1:0][DATA_W-1:0]  data_sync_q, data_sync_d;
  logic [S-1:0][FAULT_W-1:0] flt_sync_q, flt_sync_d;
  logic                      we_dly_q, we_dly_d, armed_q, armed_d;
  logic                      wr_evt_q, wr_evt_d;
  logic [ADDR_W-1:0]         wr_off_q, wr_off_d;
  logic [DATA_W-1:0]         wr_data_q, wr_data_d;
  logic [N_OUT-1:0][DATA_W-1:0] out_q, out_d;
  logic [N_OUT-1:0]          wstb_q, wstb_d;
  logic [FAULT_W-1:0]        latched_q, latched_d, mask_q, mask_d;
  logic                      xint_q, xint_d;
  logic [DATA_W-1:0]         rd_q, rd_d;
  logic                      cs_s, we_s, oe_s, rise_s;
  logic [ADDR_W-1:0]         off_s;
  logic [FAULT_W-1:0]        flt_s, clr_s;

  // Reset synchroniser: asserts asynchronously, releases on CLK.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rst_meta_q <= 1'b0;
      rst_n_q    <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_q    <= rst_meta_q;
    end
  end

  // Synchronisers, write detection/decode, fault latch and read mux.
  always_comb begin
    cs_sync_d   = {cs_sync_q[S-2:0], CSn};
    we_sync_d   = {we_sync_q[S-2:0], WEn};
    oe_sync_d   = {oe_sync_q[S-2:0], OEn};
    addr_sync_d = {addr_sync_q[S-2:0], Addr};
    data_sync_d = {data_sync_q[S-2:0], DATA_IN};
    flt_sync_d  = {flt_sync_q[S-2:0], FAULT_INPUT};
    fill_d      = {fill_q[S-2:0], 1'b1};
    cs_s        = cs_sync_q[S-1];
    we_s        = we_sync_q[S-1];
    oe_s        = oe_sync_q[S-1];
    flt_s       = flt_sync_q[S-1];
    off_s       = addr_sync_q[S-1] - BASE;

    // Only arm once a genuinely sampled WEn high has been seen, so a strobe
    // that straddled reset never produces a write after release.
    we_dly_d  = we_s;
    armed_d   = armed_q | (fill_q[S-1] & we_s);
    rise_s    = armed_q & we_s & ~we_dly_q & ~cs_s;
    wr_evt_d  = rise_s;
    wr_off_d  = off_s;
    wr_data_d = data_sync_q[S-1];

    wstb_d = '0;
    out_d  = out_q;
    mask_d = mask_q;
    clr_s  = '0;
    if (wr_evt_q) begin
      case (wr_off_q[ADDR_W-1:4])
        HI_CTL: begin
          case (wr_off_q[3:0])
            OFF_LAT:  clr_s  = wr_data_q[FAULT_W-1:0];
            OFF_MASK: mask_d = wr_data_q[FAULT_W-1:0];
            default:  clr_s  = '0;
          endcase
        end
        HI_OUT: begin
          for (int i = 0; i < N_OUT; i++) begin
            if (wr_off_q[3:0] == 4'(i)) begin
              wstb_d[i] = 1'b1;
              out_d[i]  = wr_data_q;
            end else begin
              out_d[i]  = out_q[i];
            end
          end
        end
        default: wstb_d = '0;
      endcase
    end else begin
      wstb_d = '0;
    end

    // A fault still asserted wins over a simultaneous clear.
    latched_d = (latched_q & ~clr_s) | ~flt_s;
    xint_d    = ~|(latched_q & mask_q);

    rd_d = '0;
    if (!cs_s && !oe_s) begin
      case (off_s[ADDR_W-1:4])
        HI_CTL: begin
          case (off_s[3:0])
            OFF_ID:   rd_d = ID;
            OFF_RAW:  rd_d = DATA_W'(flt_s);
            OFF_LAT:  rd_d = DATA_W'(latched_q);
            OFF_MASK: rd_d = DATA_W'(mask_q);
            default:  rd_d = '0;
          endcase
        end
        HI_OUT: begin
          for (int i = 0; i < N_OUT; i++) begin
            rd_d = rd_d | ((off_s[3:0] == 4'(i)) ? out_q[i] : '0);
          end
        end
        HI_IN: begin
          for (int i = 0; i < N_IN; i++) begin
            rd_d = rd_d | ((off_s[3:0] == 4'(i)) ? IN_REGS[i*DATA_W +: DATA_W] : '0);
          end
        end
        default: rd_d = '0;
      endcase
    end else begin
      rd_d = '0;
    end
  end

  // State registers; strobe and fault synchronisers preset to the idle (high) level.
  always_ff @(posedge CLK or negedge rst_n_q) begin
    if (!rst_n_q) begin
      cs_sync_q   <= '1;
      we_sync_q   <= '1;
      oe_sync_q   <= '1;
      flt_sync_q  <= '1;
      addr_sync_q <= '0;
      data_sync_q <= '0;
      fill_q      <= '0;
      we_dly_q    <= 1'b1;
      armed_q     <= 1'b0;
      wr_evt_q    <= 1'b0;
      wr_off_q    <= '0;
      wr_data_q   <= '0;
      out_q       <= '0;
      wstb_q      <= '0;
      latched_q   <= '0;
      mask_q      <= '1;
      xint_q      <= 1'b1;
      rd_q        <= '0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      we_sync_q   <= we_sync_d;
      oe_sync_q   <= oe_sync_d;
      flt_sync_q  <= flt_sync_d;
      addr_sync_q <= addr_sync_d;
      data_sync_q <= data_sync_d;
      fill_q      <= fill_d;
      we_dly_q    <= we_dly_d;
      armed_q     <= armed_d;
      wr_evt_q    <= wr_evt_d;
      wr_off_q    <= wr_off_d;
      wr_data_q   <= wr_data_d;
      out_q       <= out_d;
      wstb_q      <= wstb_d;
      latched_q   <= latched_d;
      mask_q      <= mask_d;
      xint_q      <= xint_d;
      rd_q        <= rd_d;
    end
  end

  assign DATA_OUT   = rd_q;
  assign DATA_OE    = ~CSn & ~OEn;
  assign OUT_REGS   = out_q;
  assign OUT_WSTB   = wstb_q;
  assign FAULT_XINT = xint_q;

endmodule

// File: tb/tb_emif_reg_bank.sv
// Self-checking bench for emif_reg_bank: bus reads/writes, strobe scoreboard, fault latch and reset.
module tb_emif_reg_bank;
  localparam int S = 2;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b1;
  logic [13:0] Addr;
  logic [15:0] DATA_IN;
  logic        CSn, WEn, OEn;
  logic [15:0] DATA_OUT;
  logic        DATA_OE;
  logic [63:0] OUT_REGS;
  logic [3:0]  OUT_WSTB;
  logic [63:0] IN_REGS;
  logic [7:0]  FAULT_INPUT;
  logic        FAULT_XINT;

  int checks = 0;
  int failures = 0;

  typedef struct { int idx; logic [15:0] data; } wr_t;
  wr_t         wr_q[$];
  logic [15:0] rd_q[$];
  logic [15:0] exp_out[4];
  wr_t         mon_e;

  always #5 CLK = ~CLK;

  emif_reg_bank dut (
    .CLK(CLK), .RESETn(RESETn), .Addr(Addr), .DATA_IN(DATA_IN),
    .CSn(CSn), .WEn(WEn), .OEn(OEn), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE),
    .OUT_REGS(OUT_REGS), .OUT_WSTB(OUT_WSTB), .IN_REGS(IN_REGS),
    .FAULT_INPUT(FAULT_INPUT), .FAULT_XINT(FAULT_XINT)
  );

  // Every strobe pulse must match the oldest expected write.
  always @(posedge CLK) begin
    #1;
    if (OUT_WSTB !== 4'b0000) begin
      checks++;
      if (wr_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_wstb: OUT_WSTB=%b, expected no strobe", OUT_WSTB);
      end else begin
        mon_e = wr_q.pop_front();
        if (OUT_WSTB !== (4'b0001 << mon_e.idx) || OUT_REGS[mon_e.idx*16 +: 16] !== mon_e.data) begin
          failures++;
          $display("FAIL wstb_event: OUT_WSTB=%b reg=%h, expected OUT_WSTB=%b reg=%h",
                   OUT_WSTB, OUT_REGS[mon_e.idx*16 +: 16], 4'b0001 << mon_e.idx, mon_e.data);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic bus_write(input logic [13:0] a, input logic [15:0] d, input int low);
    int off;
    off = int'(a) - 64;
    if (off >= 16 && off < 20) begin
      wr_q.push_back('{off - 16, d});
      exp_out[off - 16] = d;
    end
    @(negedge CLK);
    Addr = a; DATA_IN = d; CSn = 1'b0;
    tick(2);
    WEn = 1'b0;
    tick(low);
    WEn = 1'b1;
    tick(2);
    CSn = 1'b1;
    tick(S + 4);
  endtask

  task automatic bus_read(input logic [13:0] a, input logic [15:0] exp, input string name);
    logic [15:0] e;
    rd_q.push_back(exp);
    @(negedge CLK);
    Addr = a; CSn = 1'b0; OEn = 1'b0;
    tick(S + 4);
    e = rd_q.pop_front();
    checks++;
    if (DATA_OUT !== e || DATA_OE !== 1'b1) begin
      failures++;
      $display("FAIL %s: DATA_OUT=%h DATA_OE=%b, expected %h / 1", name, DATA_OUT, DATA_OE, e);
    end
    CSn = 1'b1; OEn = 1'b1;
    tick(S + 2);
  endtask

  task automatic check_regs(input string name);
    logic [63:0] exp;
    for (int i = 0; i < 4; i++) exp[i*16 +: 16] = exp_out[i];
    checks++;
    if (OUT_REGS !== exp) begin
      failures++;
      $display("FAIL %s: OUT_REGS=%h, expected %h", name, OUT_REGS, exp);
    end
  endtask

  task automatic check_xint(input logic exp, input string name);
    checks++;
    if (FAULT_XINT !== exp) begin
      failures++;
      $display("FAIL %s: FAULT_XINT=%b, expected %b", name, FAULT_XINT, exp);
    end
  endtask

  task automatic test_reset;
    CSn = 1'b1; WEn = 1'b1; OEn = 1'b1; Addr = 14'h0; DATA_IN = 16'h0;
    FAULT_INPUT = 8'hFF; IN_REGS = 64'h4444_3333_2222_1111;
    for (int i = 0; i < 4; i++) exp_out[i] = 16'h0;
    #2 RESETn = 1'b0;
    tick(3);
    checks++;
    if (OUT_REGS !== 64'h0 || OUT_WSTB !== 4'h0 || DATA_OUT !== 16'h0 || FAULT_XINT !== 1'b1 || DATA_OE !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: OUT_REGS=%h OUT_WSTB=%b DATA_OUT=%h XINT=%b OE=%b, expected 0/0/0/1/0",
               OUT_REGS, OUT_WSTB, DATA_OUT, FAULT_XINT, DATA_OE);
    end
    RESETn = 1'b1;
    tick(S + 6);
    bus_read(14'h0040, 16'h4001, "id");
    bus_read(14'h0043, 16'h00FF, "mask_reset");
    bus_read(14'h0050, 16'h0000, "out0_reset");
    bus_read(14'h0041, 16'h00FF, "raw_idle");
    bus_read(14'h0042, 16'h0000, "latched_reset");
    bus_read(14'h0062, 16'h3333, "in2");
    check_xint(1'b1, "xint_reset");
  endtask

  task automatic test_write_latency;
    @(negedge CLK);
    Addr = 14'h0052; DATA_IN = 16'hA5A5; CSn = 1'b0;
    tick(2);
    WEn = 1'b0;
    tick(10);
    wr_q.push_back('{2, 16'hA5A5});
    exp_out[2] = 16'hA5A5;
    WEn = 1'b1;
    for (int k = 1; k <= S + 2; k++) begin
      @(posedge CLK); #1;
      if (k == S + 1) begin
        checks++;
        if (OUT_REGS !== 64'h0 || OUT_WSTB !== 4'b0000) begin
          failures++;
          $display("FAIL wr_early: OUT_REGS=%h OUT_WSTB=%b, expected 0 / 0000", OUT_REGS, OUT_WSTB);
        end
      end
      if (k == S + 2) begin
        checks++;
        if (OUT_REGS !== 64'h0000_A5A5_0000_0000 || OUT_WSTB !== 4'b0100) begin
          failures++;
          $display("FAIL wr_latency: OUT_REGS=%h OUT_WSTB=%b, expected 0000a5a500000000 / 0100", OUT_REGS, OUT_WSTB);
        end
      end
    end
    @(posedge CLK); #1;
    checks++;
    if (OUT_WSTB !== 4'b0000) begin
      failures++;
      $display("FAIL wstb_single: OUT_WSTB=%b, expected 0000", OUT_WSTB);
    end
    tick(2);
    CSn = 1'b1;
    tick(6);
    bus_read(14'h0052, 16'hA5A5, "readback_r2");
    check_regs("regs_after_write");
  endtask

  task automatic test_ignored;
    bus_write(14'h0040, 16'hFFFF, 3);
    bus_write(14'h0061, 16'h1234, 3);
    bus_write(14'h0044, 16'hBEEF, 3);
    bus_write(14'h0054, 16'hBEEF, 3);
    bus_write(14'h0012, 16'hBEEF, 3);
    bus_write(14'h0452, 16'hBEEF, 3);
    bus_read(14'h0040, 16'h4001, "id_after_write");
    bus_read(14'h0061, 16'h2222, "in1_readonly");
    bus_read(14'h0070, 16'h0000, "unmapped_0x70");
    bus_read(14'h0044, 16'h0000, "unmapped_0x44");
    check_regs("regs_after_ignored");
  endtask

  task automatic test_back_to_back;
    bus_write(14'h0050, 16'h0001, 2);
    bus_write(14'h0051, 16'h8000, 2);
    bus_write(14'h0053, 16'hFFFF, 2);
    bus_write(14'h0052, 16'h5A5A, 2);
    check_regs("regs_b2b");
    bus_read(14'h0051, 16'h8000, "readback_r1");
    bus_read(14'h0053, 16'hFFFF, "readback_r3");
  endtask

  task automatic test_fault_pulse;
    @(negedge CLK);
    FAULT_INPUT = 8'hF7;
    @(negedge CLK);
    FAULT_INPUT = 8'hFF;
    for (int k = 2; k <= S + 2; k++) begin
      @(posedge CLK); #1;
      if (k == S + 1) begin
        checks++;
        if (FAULT_XINT !== 1'b1) begin
          failures++;
          $display("FAIL xint_early: FAULT_XINT=%b, expected 1", FAULT_XINT);
        end
      end
      if (k == S + 2) begin
        checks++;
        if (FAULT_XINT !== 1'b0) begin
          failures++;
          $display("FAIL xint_latency: FAULT_XINT=%b, expected 0", FAULT_XINT);
        end
      end
    end
    tick(20);
    check_xint(1'b0, "xint_sticky");
    bus_read(14'h0042, 16'h0008, "latched_f3");
    bus_read(14'h0041, 16'h00FF, "raw_after_pulse");
    bus_write(14'h0042, 16'h0008, 2);
    bus_read(14'h0042, 16'h0000, "latched_cleared");
    check_xint(1'b1, "xint_cleared");
  endtask

  task automatic test_fault_mask;
    @(negedge CLK);
    FAULT_INPUT = 8'hDF;
    tick(S + 4);
    check_xint(1'b0, "xint_f5");
    bus_write(14'h0042, 16'h0020, 2);
    bus_read(14'h0042, 16'h0020, "set_wins");
    check_xint(1'b0, "xint_f5_held");
    bus_read(14'h0041, 16'h00DF, "raw_f5");
    bus_write(14'h0043, 16'h00DF, 2);
    check_xint(1'b1, "xint_masked");
    bus_read(14'h0042, 16'h0020, "latched_masked");
    bus_read(14'h0043, 16'h00DF, "mask_readback");
    FAULT_INPUT = 8'hFF;
    bus_write(14'h0042, 16'h0020, 2);
    bus_read(14'h0042, 16'h0000, "latched_f5_cleared");
    bus_write(14'h0043, 16'h00FF, 2);
    check_xint(1'b1, "xint_unmasked_clean");
  endtask

  task automatic test_reset_mid_write;
    @(negedge CLK);
    Addr = 14'h0051; DATA_IN = 16'h1111; CSn = 1'b0; OEn = 1'b0;
    tick(2);
    WEn = 1'b0;
    tick(S + 4);
    checks++;
    if (DATA_OUT !== 16'h8000) begin
      failures++;
      $display("FAIL pre_reset_read: DATA_OUT=%h, expected 8000", DATA_OUT);
    end
    #2 RESETn = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) exp_out[i] = 16'h0;
    checks++;
    if (OUT_REGS !== 64'h0 || OUT_WSTB !== 4'h0 || DATA_OUT !== 16'h0 || FAULT_XINT !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: OUT_REGS=%h OUT_WSTB=%b DATA_OUT=%h XINT=%b, expected 0/0/0/1",
               OUT_REGS, OUT_WSTB, DATA_OUT, FAULT_XINT);
    end
    tick(3);
    RESETn = 1'b1;
    tick(8);
    OEn = 1'b1;
    WEn = 1'b1;
    tick(S + 6);
    CSn = 1'b1;
    tick(4);
    check_regs("no_write_after_reset");
    bus_write(14'h0051, 16'h2222, 3);
    bus_read(14'h0051, 16'h2222, "write_after_reset");
    check_regs("regs_after_reset_write");
  endtask

  initial begin
    test_reset();
    test_write_latency();
    test_ignored();
    test_back_to_back();
    test_fault_pulse();
    test_fault_mask();
    test_reset_mid_write();
    tick(4);
    checks++;
    if (wr_q.size() != 0) begin
      failures++;
      $display("FAIL missing_wstb: %0d expected strobes never seen, expected 0", wr_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
